wb_port_arbiter: RTL and testbench

Write-back port arbiter for the MIPS register file. It sits between the WB stage and the register file's single write port. Each cycle it grants the port to one of two sources: the pipeline's write-back (ALU or memory data) or the debug unit's register-write requests. Pipeline writes have priority. A bounded-wait counter stalls the pipeline for one cycle so that a waiting debug write is always granted. All register-file write outputs are registered.

---
 rtl/wb_port_arbiter.sv | 94 +++++++++
 tb/tb_wb_port_arbiter.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: shares the register file write port between the pipeline
// WB stage (priority) and debug register writes, with a bounded-wait forced debug slot.
//
//   state    | meaning
//   ST_IDLE  | no debug request is waiting
//   ST_WAIT  | debug request valid but denied, cnt tracks denied cycles
//   ST_FORCE | one-cycle pipeline stall, debug owns the write port
module wb_port_arbiter #(
  parameter int NB_DATA  = 32,
  parameter int NB_ADDR  = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_wb_reg_write,
  input  logic               i_wb_mem_to_reg,
  input  logic [NB_ADDR-1:0] i_wb_rd,
  input  logic [NB_DATA-1:0] i_data_alu,
  input  logic [NB_DATA-1:0] i_data_mem,
  input  logic               i_dbg_valid,
  input  logic [NB_ADDR-1:0] i_dbg_addr,
  input  logic [NB_DATA-1:0] i_dbg_data,
  output logic               o_dbg_ready,
  output logic               o_stall,
  output logic               o_rf_we,
  output logic [NB_ADDR-1:0] o_rf_addr,
  output logic [NB_DATA-1:0] o_rf_data,
  output logic               o_rf_src
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } state_t;

  localparam logic [3:0] CNT_LAST = 4'(MAX_WAIT - 1);

  state_t             state;
  logic [3:0]         cnt;
  logic               pipe_wr;
  logic               xfer;
  logic               denied;
  logic [NB_DATA-1:0] pipe_data;

  assign o_stall     = (state == ST_FORCE);
  // A pipeline write to r0 is no write at all, so the debug unit may take that slot.
  assign pipe_wr     = i_wb_reg_write && (i_wb_rd != '0) && !o_stall;
  assign o_dbg_ready = o_stall || !pipe_wr;
  assign xfer        = i_dbg_valid && o_dbg_ready;
  assign denied      = i_dbg_valid && !o_dbg_ready;
  assign pipe_data   = i_wb_mem_to_reg ? i_data_mem : i_data_alu;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      o_rf_we   <= 1'b0;
      o_rf_addr <= '0;
      o_rf_data <= '0;
      o_rf_src  <= 1'b0;
    end else begin
      cnt <= denied ? cnt + 4'd1 : 4'd0;

      case (state)
        ST_IDLE: begin
          // cnt is always zero here, so MAX_WAIT=1 forces on the first denial
          if (denied) state <= (cnt == CNT_LAST) ? ST_FORCE : ST_WAIT;
        end
        ST_WAIT: begin
          if (!denied)                state <= ST_IDLE;
          else if (cnt == CNT_LAST)   state <= ST_FORCE;
        end
        ST_FORCE: state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase

      if (pipe_wr) begin
        o_rf_we   <= 1'b1;
        o_rf_addr <= i_wb_rd;
        o_rf_data <= pipe_data;
        o_rf_src  <= 1'b0;
      end else if (xfer) begin
        o_rf_we   <= (i_dbg_addr != '0);
        o_rf_addr <= i_dbg_addr;
        o_rf_data <= i_dbg_data;
        o_rf_src  <= 1'b1;
      end else begin
        o_rf_we   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: expected register-file outputs are queued when
// stimulus is driven and compared one cycle later; a MAX_WAIT=1 copy covers the force edge case.
module tb_wb_port_arbiter;

  logic        clk;
  logic        rst;
  logic        wb_we;
  logic        m2r;
  logic [4:0]  rd;
  logic [31:0] alu;
  logic [31:0] mem;
  logic        dv;
  logic [4:0]  da;
  logic [31:0] dd;

  logic        dbg_ready, stall, rf_we, rf_src;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic        d1_ready, d1_stall, d1_we, d1_src;
  logic [4:0]  d1_addr;
  logic [31:0] d1_data;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct packed {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        src;
    logic        stall;
  } exp_t;

  exp_t        q[$];
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic        m_src;

  wb_port_arbiter #(.NB_DATA(32), .NB_ADDR(5), .MAX_WAIT(4)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_wb_reg_write(wb_we), .i_wb_mem_to_reg(m2r), .i_wb_rd(rd),
    .i_data_alu(alu), .i_data_mem(mem),
    .i_dbg_valid(dv), .i_dbg_addr(da), .i_dbg_data(dd),
    .o_dbg_ready(dbg_ready), .o_stall(stall),
    .o_rf_we(rf_we), .o_rf_addr(rf_addr), .o_rf_data(rf_data), .o_rf_src(rf_src)
  );

  wb_port_arbiter #(.NB_DATA(32), .NB_ADDR(5), .MAX_WAIT(1)) dut1 (
    .i_clk(clk), .i_reset(rst),
    .i_wb_reg_write(wb_we), .i_wb_mem_to_reg(m2r), .i_wb_rd(rd),
    .i_data_alu(alu), .i_data_mem(mem),
    .i_dbg_valid(dv), .i_dbg_addr(da), .i_dbg_data(dd),
    .o_dbg_ready(d1_ready), .o_stall(d1_stall),
    .o_rf_we(d1_we), .o_rf_addr(d1_addr), .o_rf_data(d1_data), .o_rf_src(d1_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic drive(input logic we_p, input logic m2r_p, input logic [4:0] rd_p,
                       input logic [31:0] alu_p, input logic [31:0] mem_p,
                       input logic dv_p, input logic [4:0] da_p, input logic [31:0] dd_p);
    wb_we = we_p; m2r = m2r_p; rd = rd_p; alu = alu_p; mem = mem_p;
    dv = dv_p; da = da_p; dd = dd_p;
    #1;
  endtask

  // upd=1 means addr/data/src are captured; otherwise they hold their previous values
  task automatic exp_push(input logic we_e, input logic upd, input logic [4:0] a,
                          input logic [31:0] d, input logic s, input logic st);
    exp_t e;
    if (upd) begin
      m_addr = a; m_data = d; m_src = s;
    end
    e.we = we_e; e.addr = m_addr; e.data = m_data; e.src = m_src; e.stall = st;
    q.push_back(e);
  endtask

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    n_checks++;
    assert (q.size() != 0) else begin
      n_errors++;
      $error("FAIL %s scoreboard empty observed=0 expected=1", tag);
    end
    if (q.size() != 0) begin
      e = q.pop_front();
      chk({tag, ".we"},    32'(rf_we),   32'(e.we));
      chk({tag, ".addr"},  32'(rf_addr), 32'(e.addr));
      chk({tag, ".data"},  rf_data,      e.data);
      chk({tag, ".src"},   32'(rf_src),  32'(e.src));
      chk({tag, ".stall"}, 32'(stall),   32'(e.stall));
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("reset.we",    32'(rf_we),     0);
    chk("reset.addr",  32'(rf_addr),   0);
    chk("reset.data",  rf_data,        0);
    chk("reset.src",   32'(rf_src),    0);
    chk("reset.stall", 32'(stall),     0);
    chk("reset.ready", 32'(dbg_ready), 1);
    m_addr = '0; m_data = '0; m_src = 1'b0;
    rst = 1'b0;

    // pipeline only
    drive(1, 1, 2, 32'h1, 32'h2, 0, 0, 0);
    chk("pipe_mem.ready", 32'(dbg_ready), 0);
    exp_push(1, 1, 2, 32'h2, 0, 0);
    tick("pipe_mem");
    drive(1, 0, 2, 32'h1, 32'h2, 0, 0, 0);
    exp_push(1, 1, 2, 32'h1, 0, 0);
    tick("pipe_alu");
    drive(1, 0, 0, 32'h1, 32'h2, 0, 0, 0);
    chk("pipe_r0.ready", 32'(dbg_ready), 1);
    exp_push(0, 0, 0, 0, 0, 0);
    tick("pipe_r0");

    // debug only
    drive(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF);
    chk("dbg5.ready", 32'(dbg_ready), 1);
    exp_push(1, 1, 5, 32'hDEADBEEF, 1, 0);
    tick("dbg5");
    drive(0, 0, 0, 0, 0, 1, 0, 32'h1234);
    chk("dbg_r0.ready", 32'(dbg_ready), 1);
    exp_push(0, 1, 0, 32'h1234, 1, 0);
    tick("dbg_r0");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_push(0, 0, 0, 0, 0, 0);
    tick("idle0");

    // contention: 4 denied cycles, then the forced slot
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 3, 32'h33, 32'h0, 1, 7, 32'h77);
      chk($sformatf("cont%0d.ready", i), 32'(dbg_ready), 0);
      exp_push(1, 1, 3, 32'h33, 0, (i == 3));
      tick($sformatf("cont%0d", i));
    end
    drive(1, 0, 3, 32'h33, 32'h0, 1, 7, 32'h77);
    chk("force.ready", 32'(dbg_ready), 1);
    exp_push(1, 1, 7, 32'h77, 1, 0);
    tick("force");
    drive(1, 0, 3, 32'h33, 32'h0, 0, 0, 0);
    chk("resume.ready", 32'(dbg_ready), 0);
    exp_push(1, 1, 3, 32'h33, 0, 0);
    tick("resume");

    // two denials, then pipeline idles and debug gets through without a stall
    for (int i = 0; i < 2; i++) begin
      drive(1, 0, 4, 32'h44, 32'h0, 1, 9, 32'h99);
      chk($sformatf("late%0d.ready", i), 32'(dbg_ready), 0);
      exp_push(1, 1, 4, 32'h44, 0, 0);
      tick($sformatf("late%0d", i));
    end
    drive(0, 0, 4, 32'h44, 32'h0, 1, 9, 32'h99);
    chk("late_xfer.ready", 32'(dbg_ready), 1);
    exp_push(1, 1, 9, 32'h99, 1, 0);
    tick("late_xfer");
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    exp_push(0, 0, 0, 0, 0, 0);
    tick("late_idle");

    // reset while waiting with cnt=3: wait count must restart from zero
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 6, 32'h66, 32'h0, 1, 10, 32'hAA);
      exp_push(1, 1, 6, 32'h66, 0, 0);
      tick($sformatf("prerst%0d", i));
    end
    rst = 1'b1;
    drive(1, 0, 6, 32'h66, 32'h0, 1, 10, 32'hAA);
    chk("midrst.ready", 32'(dbg_ready), 0);
    exp_push(0, 1, 0, 32'h0, 0, 0);
    tick("midrst");
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1, 0, 6, 32'h66, 32'h0, 1, 10, 32'hAA);
      chk($sformatf("postrst%0d.ready", i), 32'(dbg_ready), 0);
      exp_push(1, 1, 6, 32'h66, 0, (i == 3));
      tick($sformatf("postrst%0d", i));
    end
    drive(1, 0, 6, 32'h66, 32'h0, 1, 10, 32'hAA);
    chk("postrst_force.ready", 32'(dbg_ready), 1);
    exp_push(1, 1, 10, 32'hAA, 1, 0);
    tick("postrst_force");
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      exp_push(0, 0, 0, 0, 0, 0);
      tick($sformatf("idle%0d", i + 1));
    end

    // MAX_WAIT=1 copy: valid dropped on the FORCE cycle spends the stall with no write
    drive(1, 0, 8, 32'h88, 32'h0, 1, 11, 32'hBB);
    chk("mw1_a.ready", 32'(dbg_ready), 0);
    chk("mw1_a.d1_ready", 32'(d1_ready), 0);
    exp_push(1, 1, 8, 32'h88, 0, 0);
    tick("mw1_a");
    chk("mw1_a.d1_stall", 32'(d1_stall), 1);
    drive(1, 0, 8, 32'h88, 32'h0, 0, 0, 0);
    chk("mw1_b.ready", 32'(dbg_ready), 0);
    chk("mw1_b.d1_ready", 32'(d1_ready), 1);
    exp_push(1, 1, 8, 32'h88, 0, 0);
    tick("mw1_b");
    chk("mw1_b.d1_we", 32'(d1_we), 0);
    chk("mw1_b.d1_stall", 32'(d1_stall), 0);
    drive(1, 0, 8, 32'h88, 32'h0, 0, 0, 0);
    chk("mw1_c.d1_ready", 32'(d1_ready), 0);
    exp_push(1, 1, 8, 32'h88, 0, 0);
    tick("mw1_c");
    chk("mw1_c.d1_we",   32'(d1_we),   1);
    chk("mw1_c.d1_addr", 32'(d1_addr), 8);
    chk("mw1_c.d1_data", d1_data,      32'h88);
    chk("mw1_c.d1_src",  32'(d1_src),  0);

    n_checks++;
    assert (q.size() == 0) else begin
      n_errors++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
